// File: rtl/aes_pkg.sv
// Shared AES constants and the byte packer state encoding.
package aes_pkg;

    localparam int AES_BLOCK_BITS  = 128;
    localparam int AES_BLOCK_BYTES = 16;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        HOLD   = 2'd1,
        PADBLK = 2'd2
    } packer_state_e;

    // Pad value for bytes after lastIdx; PKCS#7 stores the number of pad bytes.
    function automatic logic [7:0] padByte(input logic [3:0] lastIdx, input logic pkcs7);
        return pkcs7 ? {4'h0, 4'hF - lastIdx} : 8'h00;
    endfunction

endpackage

// File: rtl/aes_byte_packer.sv
// Packs a byte stream into 128-bit AES plaintext blocks (byte 0 at bits [0:7]),
// padding the final short block with zeros or PKCS#7.
module aes_byte_packer
    import aes_pkg::*;
#(
    parameter int PKCS7 = 0,
    parameter int N     = AES_BLOCK_BITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [0:N-1] out_block,
    output logic [4:0]   out_nbytes,
    output logic         out_last,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam logic PadPkcs7 = (PKCS7 != 0);

    packer_state_e state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [0:N-1]  block_q, block_d;
    logic [4:0]    nbytes_q, nbytes_d;
    logic          last_q, last_d;
    logic          padPend_q, padPend_d;

    logic [3:0]    loadIdx;
    logic [0:N-1]  loadBase;
    logic [0:N-1]  loadBlock;
    logic [0:N-1]  closeBlock;
    logic [7:0]    padVal;
    logic          loadCloses;
    logic          fullLast;

    // A byte accepted in HOLD overlaps the handshake, so it starts a fresh block at index 0.
    always_comb begin
        loadIdx    = (state_q == FILL) ? cnt_q : 4'd0;
        loadBase   = (state_q == FILL) ? block_q : '0;
        padVal     = padByte(loadIdx, PadPkcs7);
        loadCloses = in_last || (loadIdx == 4'hF);
        fullLast   = PadPkcs7 && in_last && (loadIdx == 4'hF);
        loadBlock  = loadBase;
        closeBlock = loadBase;
        for (int k = 0; k < AES_BLOCK_BYTES; k++) begin
            if (4'(k) == loadIdx) begin
                loadBlock[8*k +: 8]  = in_data;
                closeBlock[8*k +: 8] = in_data;
            end else if (4'(k) > loadIdx) begin
                closeBlock[8*k +: 8] = padVal;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        block_d   = block_q;
        nbytes_d  = nbytes_q;
        last_d    = last_q;
        padPend_d = padPend_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            FILL:    in_ready = 1'b1;
            // A pending PKCS#7 pad block must go out before any new message byte.
            HOLD: begin
                in_ready  = out_ready && !padPend_q;
                out_valid = 1'b1;
            end
            PADBLK:  out_valid = 1'b1;
            default: state_d = FILL;
        endcase

        if (out_valid && out_ready) begin
            state_d   = FILL;
            cnt_d     = '0;
            block_d   = '0;
            nbytes_d  = '0;
            last_d    = 1'b0;
            padPend_d = 1'b0;
            if (padPend_q) begin
                state_d = PADBLK;
                block_d = {AES_BLOCK_BYTES{8'h10}};
                last_d  = 1'b1;
            end
        end

        if (in_valid && in_ready) begin
            cnt_d = loadIdx + 4'd1;
            if (loadCloses) begin
                state_d   = HOLD;
                block_d   = closeBlock;
                nbytes_d  = {1'b0, loadIdx} + 5'd1;
                last_d    = in_last && !fullLast;
                padPend_d = fullLast;
            end else begin
                state_d = FILL;
                block_d = loadBlock;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            cnt_q     <= '0;
            block_q   <= '0;
            nbytes_q  <= '0;
            last_q    <= 1'b0;
            padPend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            block_q   <= block_d;
            nbytes_q  <= nbytes_d;
            last_q    <= last_d;
            padPend_q <= padPend_d;
        end
    end

    assign out_block  = block_q;
    assign out_nbytes = nbytes_q;
    assign out_last   = last_q;

endmodule

// File: tb/tb_aes_byte_packer.sv
// Directed bench for aes_byte_packer: zero-pad and PKCS#7 instances share stimulus,
// and sel picks which one is compared.
module tb_aes_byte_packer;

    typedef struct {
        int           len;
        logic [7:0]   first;
        logic         pk;
        logic [0:127] expBlock;
        logic [4:0]   expN;
        logic         expLast;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   inData;
    logic         inValid;
    logic         inLast;
    logic         outReady;
    logic         sel;

    logic         inReady0, inReady1, valid0, valid1, last0, last1;
    logic [0:127] block0, block1;
    logic [4:0]   n0, n1;

    logic         selReady, selValid, selLast;
    logic [0:127] selBlock;
    logic [4:0]   selN;

    int           checkCount = 0;
    int           passCount  = 0;
    logic [0:127] gotBlk[$];
    logic [4:0]   gotN[$];
    logic         gotLast[$];
    vec_t         vecs[7];

    assign selReady = sel ? inReady1 : inReady0;
    assign selValid = sel ? valid1 : valid0;
    assign selLast  = sel ? last1 : last0;
    assign selBlock = sel ? block1 : block0;
    assign selN     = sel ? n1 : n0;

    always #5 clk = ~clk;

    aes_byte_packer #(.PKCS7(0), .N(128)) u0 (
        .clk(clk), .rst_n(rst_n), .in_data(inData), .in_valid(inValid), .in_last(inLast),
        .in_ready(inReady0), .out_block(block0), .out_nbytes(n0), .out_last(last0),
        .out_valid(valid0), .out_ready(outReady)
    );

    aes_byte_packer #(.PKCS7(1), .N(128)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(inData), .in_valid(inValid), .in_last(inLast),
        .in_ready(inReady1), .out_block(block1), .out_nbytes(n1), .out_last(last1),
        .out_valid(valid1), .out_ready(outReady)
    );

    task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    task automatic applyReset();
        rst_n    = 1'b0;
        inValid  = 1'b0;
        inData   = 8'h00;
        inLast   = 1'b0;
        outReady = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Streams len bytes from first upward, stalling out_ready for the first stall cycles a block is offered.
    task automatic applyStimulus(input logic [7:0] first, input int len, input int stall,
                                 input logic [0:127] stallExp);
        int   idx       = 0;
        int   stallLeft = stall;
        logic stalling;
        logic acc;
        gotBlk.delete();
        gotN.delete();
        gotLast.delete();
        for (int cyc = 0; cyc < len + stall + 8; cyc++) begin
            if (idx < len) begin
                inValid = 1'b1;
                inData  = first + 8'(idx);
                inLast  = (idx == len - 1);
            end else begin
                inValid = 1'b0;
                inData  = 8'h00;
                inLast  = 1'b0;
            end
            stalling = selValid && (stallLeft > 0);
            if (stalling) begin
                outReady = 1'b0;
                stallLeft--;
            end else begin
                outReady = 1'b1;
            end
            @(negedge clk);
            if (stalling) begin
                checkOutput("stallInReady", 128'(selReady), 128'(1'b0));
                checkOutput("stallBlock", selBlock, stallExp);
            end
            if (selValid && outReady) begin
                gotBlk.push_back(selBlock);
                gotN.push_back(selN);
                gotLast.push_back(selLast);
            end
            acc = inValid && selReady;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        inValid  = 1'b0;
        inLast   = 1'b0;
        outReady = 1'b0;
        checkOutput("bytesAccepted", 128'(idx), 128'(len));
    endtask

    task automatic checkBlock(input string name, input int i, input logic [0:127] expBlock,
                              input logic [4:0] expN, input logic expLast);
        logic [0:127] b;
        logic [4:0]   n;
        logic         l;
        b = (gotBlk.size() > i) ? gotBlk[i] : 'x;
        n = (gotN.size() > i) ? gotN[i] : 'x;
        l = (gotLast.size() > i) ? gotLast[i] : 1'bx;
        checkOutput({name, "_block"}, b, expBlock);
        checkOutput({name, "_nbytes"}, 128'(n), 128'(expN));
        checkOutput({name, "_last"}, 128'(l), 128'(expLast));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{16, 8'h00, 1'b0, 128'h00010203_04050607_08090A0B_0C0D0E0F, 5'd16, 1'b1};
        vecs[1] = '{5,  8'hA1, 1'b1, 128'hA1A2A3A4_A50B0B0B_0B0B0B0B_0B0B0B0B, 5'd5,  1'b1};
        vecs[2] = '{1,  8'h5A, 1'b0, 128'h5A000000_00000000_00000000_00000000, 5'd1,  1'b1};
        vecs[3] = '{3,  8'h11, 1'b0, 128'h11121300_00000000_00000000_00000000, 5'd3,  1'b1};
        vecs[4] = '{15, 8'h00, 1'b1, 128'h00010203_04050607_08090A0B_0C0D0E01, 5'd15, 1'b1};
        vecs[5] = '{1,  8'h5A, 1'b1, 128'h5A0F0F0F_0F0F0F0F_0F0F0F0F_0F0F0F0F, 5'd1,  1'b1};
        vecs[6] = '{16, 8'hF0, 1'b0, 128'hF0F1F2F3_F4F5F6F7_F8F9FAFB_FCFDFEFF, 5'd16, 1'b1};

        sel = 1'b0;
        applyReset();
        @(negedge clk);
        checkOutput("resetValid", 128'(valid0), 128'(1'b0));
        checkOutput("resetInReady", 128'(inReady0), 128'(1'b1));
        checkOutput("resetBlock", block0, 128'h0);
        checkOutput("resetNbytes", 128'(n0), 128'(5'd0));
        checkOutput("resetLast", 128'(last0), 128'(1'b0));
        @(posedge clk);
        #1;

        for (int v = 0; v < 7; v++) begin
            sel = vecs[v].pk;
            applyReset();
            applyStimulus(vecs[v].first, vecs[v].len, 0, '0);
            checkOutput($sformatf("vec%0d_count", v), 128'(gotBlk.size()), 128'd1);
            checkBlock($sformatf("vec%0d", v), 0, vecs[v].expBlock, vecs[v].expN, vecs[v].expLast);
        end

        // Full final block under PKCS#7 is followed by a dedicated pad block.
        sel = 1'b1;
        applyReset();
        for (int i = 0; i < 16; i++) begin
            inValid = 1'b1;
            inData  = 8'(i);
            inLast  = (i == 15);
            @(posedge clk);
            #1;
        end
        inValid = 1'b0;
        inLast  = 1'b0;
        @(negedge clk);
        checkOutput("padData_valid", 128'(valid1), 128'(1'b1));
        checkOutput("padData_block", block1, 128'h00010203_04050607_08090A0B_0C0D0E0F);
        checkOutput("padData_nbytes", 128'(n1), 128'(5'd16));
        checkOutput("padData_last", 128'(last1), 128'(1'b0));
        checkOutput("padData_inReady", 128'(inReady1), 128'(1'b0));
        outReady = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("padBlk_valid", 128'(valid1), 128'(1'b1));
        checkOutput("padBlk_block", block1, 128'h10101010_10101010_10101010_10101010);
        checkOutput("padBlk_nbytes", 128'(n1), 128'(5'd0));
        checkOutput("padBlk_last", 128'(last1), 128'(1'b1));
        checkOutput("padBlk_inReady", 128'(inReady1), 128'(1'b0));
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("padDone_valid", 128'(valid1), 128'(1'b0));
        checkOutput("padDone_inReady", 128'(inReady1), 128'(1'b1));
        @(posedge clk);
        #1;

        // 32 bytes back-to-back with a 3-cycle downstream stall on the first block.
        sel = 1'b0;
        applyReset();
        applyStimulus(8'h40, 32, 3, 128'h40414243_44454647_48494A4B_4C4D4E4F);
        checkOutput("stream_count", 128'(gotBlk.size()), 128'd2);
        checkBlock("stream0", 0, 128'h40414243_44454647_48494A4B_4C4D4E4F, 5'd16, 1'b0);
        checkBlock("stream1", 1, 128'h50515253_54555657_58595A5B_5C5D5E5F, 5'd16, 1'b1);
        if (gotBlk.size() > 1) checkOutput("stream1_byte0", 128'(gotBlk[1][0:7]), 128'(8'h50));
        else checkOutput("stream1_byte0", 128'hx, 128'(8'h50));

        // Reset mid-block drops the partial data.
        sel = 1'b0;
        applyReset();
        outReady = 1'b1;
        for (int i = 0; i < 7; i++) begin
            inValid = 1'b1;
            inData  = 8'h70 + 8'(i);
            inLast  = 1'b0;
            @(posedge clk);
            #1;
        end
        inValid = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        checkOutput("midReset_valid", 128'(valid0), 128'(1'b0));
        checkOutput("midReset_block", block0, 128'h0);
        checkOutput("midReset_nbytes", 128'(n0), 128'(5'd0));
        checkOutput("midReset_last", 128'(last0), 128'(1'b0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("postReset_inReady", 128'(inReady0), 128'(1'b1));
        checkOutput("postReset_valid", 128'(valid0), 128'(1'b0));
        @(posedge clk);
        #1;
        applyStimulus(8'h80, 16, 0, '0);
        checkOutput("postReset_count", 128'(gotBlk.size()), 128'd1);
        checkBlock("postReset", 0, 128'h80818283_84858687_88898A8B_8C8D8E8F, 5'd16, 1'b1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
